// File: rtl/btn_event_pkg.sv
// Shared types for the button event scheduler: event codes and hold-FSM state encoding.
package btn_event_pkg;

  typedef enum logic [1:0] {
    EVT_PRESS   = 2'd0,
    EVT_RELEASE = 2'd1,
    EVT_LONG    = 2'd2,
    EVT_REPEAT  = 2'd3
  } evt_code_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HELD = 2'd1,
    ST_LONG = 2'd2
  } btn_state_t;

endpackage

// File: rtl/btn_event_scheduler_if.sv
// Event stream between the scheduler (master) and its consumer (slave).
interface btn_event_scheduler_if
  import btn_event_pkg::*;
#(
  parameter int IDX_W = 2
) ();

  // Handshake: an event transfers on a cycle where evt_valid_o & evt_ready_i;
  // while evt_valid_o is high and evt_ready_i low, btn/code are held stable.
  logic             evt_valid_o;
  logic             evt_ready_i;
  logic [IDX_W-1:0] evt_btn_o;
  evt_code_t        evt_code_o;

  modport master (output evt_valid_o, evt_btn_o, evt_code_o, input evt_ready_i);
  modport slave  (input evt_valid_o, evt_btn_o, evt_code_o, output evt_ready_i);

endinterface

// File: rtl/btn_hold_fsm.sv
// Per-button hold timer: IDLE/HELD/LONG with a saturating counter and a raise strobe.
// REPEAT generation in LONG is enabled by defining BTN_REPEAT_EN.
module btn_hold_fsm
  import btn_event_pkg::*;
#(
  parameter int CNT_W        = 20,
  parameter int LONG_TICKS   = 500000,
  parameter int REPEAT_TICKS = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       down,
  input  logic       up,
  output logic       raise,
  output evt_code_t  code,
  output btn_state_t state
);

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_TICKS - 1);
`ifdef BTN_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_TICKS - 1);
`endif

  logic [CNT_W-1:0] cnt;

  // Raise is decoded in the cycle of the pulse so the slot captures it at that edge.
  always_comb begin
    raise = 1'b0;
    code  = EVT_PRESS;
    case (state)
      ST_IDLE: if (down && !up) raise = 1'b1;
      ST_HELD: begin
        if (up) begin
          raise = 1'b1;
          code  = EVT_RELEASE;
        end else if (cnt == LONG_LAST) begin
          raise = 1'b1;
          code  = EVT_LONG;
        end
      end
      ST_LONG: begin
        if (up) begin
          raise = 1'b1;
          code  = EVT_RELEASE;
        end
`ifdef BTN_REPEAT_EN
        else if (cnt == REP_LAST) begin
          raise = 1'b1;
          code  = EVT_REPEAT;
        end
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: if (down && !up) begin
          state <= ST_HELD;
          cnt   <= '0;
        end
        ST_HELD: begin
          if (up) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else if (cnt == LONG_LAST) begin
            state <= ST_LONG;
            cnt   <= '0;
          end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_LONG: begin
          if (up) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end
`ifdef BTN_REPEAT_EN
          else if (cnt == REP_LAST) cnt <= '0;
          else if (cnt != '1) cnt <= cnt + 1'b1;
`endif
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/btn_event_scheduler.sv
// Per-button hold FSMs feeding one-deep event slots, serialised round-robin onto one event stream.
// Optional REPEAT events: define BTN_REPEAT_EN.
module btn_event_scheduler
  import btn_event_pkg::*;
#(
  parameter int N_BTN        = 4,
  parameter int IDX_W        = 2,
  parameter int CNT_W        = 20,
  parameter int LONG_TICKS   = 500000,
  parameter int REPEAT_TICKS = 100000
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic [N_BTN-1:0]              sw_down_i,
  input  logic [N_BTN-1:0]              sw_up_i,
  input  logic                          ovf_clr_i,
  output logic [N_BTN-1:0]              ovf_o,
  output btn_state_t [N_BTN-1:0]        state_o,
  btn_event_scheduler_if.master         evt
);

  logic [N_BTN-1:0] raise;
  evt_code_t        raise_code [N_BTN];
  logic [N_BTN-1:0] slot_vld;
  evt_code_t        slot_code  [N_BTN];
  logic [N_BTN-1:0] grant;
  logic [IDX_W-1:0] last_grant;
  logic [IDX_W-1:0] win;
  logic             found;
  logic             load;

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    btn_hold_fsm #(
      .CNT_W       (CNT_W),
      .LONG_TICKS  (LONG_TICKS),
      .REPEAT_TICKS(REPEAT_TICKS)
    ) u_fsm (
      .clk  (clk_i),
      .rst_n(rst_n_i),
      .down (sw_down_i[i]),
      .up   (sw_up_i[i]),
      .raise(raise[i]),
      .code (raise_code[i]),
      .state(state_o[i])
    );
  end

  assign load = !evt.evt_valid_o || evt.evt_ready_i;

  // Search starts just after the last winner so every occupied slot is served in turn.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < N_BTN; k++) begin
      int               idx;
      logic [IDX_W-1:0] cand;
      idx  = (int'(last_grant) + 1 + k) % N_BTN;
      cand = IDX_W'(idx);
      if (!found && slot_vld[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    grant = '0;
    if (load && found) grant[win] = 1'b1;
  end

  // A slot being drained this cycle can accept a new event without loss.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      slot_vld <= '0;
      ovf_o    <= '0;
      for (int i = 0; i < N_BTN; i++) slot_code[i] <= EVT_PRESS;
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        if (raise[i] && (!slot_vld[i] || grant[i])) begin
          slot_vld[i]  <= 1'b1;
          slot_code[i] <= raise_code[i];
        end else if (grant[i]) begin
          slot_vld[i] <= 1'b0;
        end
        if (raise[i] && slot_vld[i] && !grant[i]) ovf_o[i] <= 1'b1;
        else if (ovf_clr_i)                       ovf_o[i] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      evt.evt_valid_o <= 1'b0;
      evt.evt_btn_o   <= '0;
      evt.evt_code_o  <= EVT_PRESS;
      last_grant      <= IDX_W'(N_BTN - 1);
    end else if (load) begin
      evt.evt_valid_o <= found;
      if (found) begin
        evt.evt_btn_o  <= win;
        evt.evt_code_o <= slot_code[win];
        last_grant     <= win;
      end
    end
  end

endmodule
